// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator frame protocol. The controller and the
// summing datapath both import this so they agree on frame length and phases.
package acc_pkg;

  // Receiver lock state: hunting for a frame start, or tracking frames.
  typedef enum logic [0:0] {
    StHunt = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Phase counter type; wide enough for FRAME_LEN phases.
  typedef logic [1:0] ph_t;

  localparam int unsigned FRAME_LEN = 4;
  localparam ph_t         PH_FIRST  = 2'd0;
  localparam ph_t         PH_LAST   = 2'd3;

  // Depth of the completed-sum queue toward the consumer.
  localparam int unsigned FIFO_DEPTH = 2;

  // True on the phase whose sample closes the frame.
  function automatic logic is_last_phase(input ph_t ph);
    return ph == PH_LAST;
  endfunction

endpackage

// File: rtl/acc_out_fifo.sv
// Two-entry show-ahead FIFO holding completed frame sums. A push while full is
// accepted only when a pop happens on the same edge; otherwise it is ignored and
// the caller is expected to flag the drop.
module acc_out_fifo #(
  parameter int unsigned ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ACC_W-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [ACC_W-1:0] head
);

  logic [ACC_W-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic             push_ok;
  logic             pop_ok;

  // Status decode and accepted-transfer qualification.
  always_comb begin
    empty   = (count_q == 2'd0);
    full    = (count_q == 2'd2);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    // Head forced to zero when empty so the output matches reset after a drain.
    head    = empty ? '0 : mem_q[rd_ptr_q];
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/acc_sum_unit.sv
// Frame-summing receiver for the sel/en accumulator protocol. Sums the four
// samples of each frame, flags misplaced strobes, and queues results for a
// valid/ready consumer.
module acc_sum_unit
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [ACC_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              locked,
  output logic              frame_err,
  output logic              ovf
);

  state_e           state_q, state_d;
  ph_t              ph_q, ph_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] din_ext;
  logic [ACC_W-1:0] sum;
  logic             commit;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ACC_W-1:0] fifo_head;

  // Zero-extend the sample; the adder wraps naturally at ACC_W bits.
  always_comb begin
    din_ext = ACC_W'(din);
    sum     = acc_q + din_ext;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, phase, accumulator, error and commit decisions.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    acc_d   = acc_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StHunt: begin
        // Only a frame start is meaningful while hunting.
        if (sel) begin
          state_d = StRun;
          acc_d   = din_ext;
          ph_d    = 2'd1;
        end else begin
          ph_d = PH_FIRST;
        end
      end
      StRun: begin
        if (sel) begin
          // sel always restarts; it wins over a simultaneous en, so at most one error.
          err_d = (ph_q != PH_FIRST);
          acc_d = din_ext;
          ph_d  = 2'd1;
        end else if (ph_q == PH_FIRST) begin
          // Between frames with no start strobe: lost framing.
          err_d   = 1'b1;
          state_d = StHunt;
        end else if (is_last_phase(ph_q)) begin
          if (en) begin
            commit = 1'b1;
            ph_d   = PH_FIRST;
          end else begin
            err_d   = 1'b1;
            state_d = StHunt;
            ph_d    = PH_FIRST;
          end
        end else begin
          if (en) begin
            // Early end strobe: frame is short, discard it.
            err_d   = 1'b1;
            state_d = StHunt;
            ph_d    = PH_FIRST;
          end else begin
            acc_d = sum;
            ph_d  = ph_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = StHunt;
        ph_d    = PH_FIRST;
      end
    endcase
  end

  // Sticky overflow: a commit is lost only when full and nothing drains this edge.
  always_comb begin
    ovf_d = ovf_q | (commit & fifo_full & ~dout_ready);
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q  <= PH_FIRST;
      acc_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      acc_q <= acc_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  acc_out_fifo #(
    .ACC_W (ACC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (commit),
    .push_data (sum),
    .full      (fifo_full),
    .pop       (dout_ready),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Outputs, all driven from registers.
  always_comb begin
    locked     = (state_q == StRun);
    frame_err  = err_q;
    ovf        = ovf_q;
    dout       = fifo_head;
    dout_valid = ~fifo_empty;
  end

endmodule

// File: tb/tb_acc_sum_unit.sv
// Bench for acc_sum_unit: directed protocol scenarios followed by random traffic,
// checked cycle by cycle against a frame-level reference model. A second instance
// with a 9-bit accumulator shares the stimulus to exercise wrap-around.
module tb_acc_sum_unit;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       en = 1'b0;
  logic [7:0] din = 8'd0;
  logic       dout_ready = 1'b0;

  logic [9:0] dout;
  logic       dout_valid, locked, frame_err, ovf;
  logic [8:0] dout9;
  logic       dout_valid9, locked9, frame_err9, ovf9;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_sum_unit #(.DATA_W(8), .ACC_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .en         (en),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .locked     (locked),
    .frame_err  (frame_err),
    .ovf        (ovf)
  );

  acc_sum_unit #(.DATA_W(8), .ACC_W(9)) dut9 (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .en         (en),
    .din        (din),
    .dout       (dout9),
    .dout_valid (dout_valid9),
    .dout_ready (dout_ready),
    .locked     (locked9),
    .frame_err  (frame_err9),
    .ovf        (ovf9)
  );

  // Reference model: frame tracking with a sample count, full-precision sums in a queue.
  bit m_in_frame;
  int m_cnt;
  int m_sum;
  int m_q[$];
  bit m_err;
  bit m_ovf;

  task automatic model_update(input logic s, input logic e, input logic [7:0] d,
                              input logic r, input logic rs);
    bit commit;
    bit pop;
    int csum;
    commit = 0;
    csum   = 0;
    if (rs) begin
      m_in_frame = 0;
      m_cnt      = 0;
      m_sum      = 0;
      m_q.delete();
      m_err      = 0;
      m_ovf      = 0;
      return;
    end
    pop   = (m_q.size() > 0) && r;
    m_err = 0;
    if (s) begin
      if (m_in_frame && m_cnt != 0) m_err = 1;
      m_in_frame = 1;
      m_sum      = int'(d);
      m_cnt      = 1;
    end else if (m_in_frame) begin
      if (m_cnt == 0) begin
        m_err      = 1;
        m_in_frame = 0;
      end else if (m_cnt < FRAME_LEN - 1) begin
        if (e) begin
          m_err      = 1;
          m_in_frame = 0;
          m_cnt      = 0;
        end else begin
          m_sum += int'(d);
          m_cnt++;
        end
      end else if (e) begin
        commit = 1;
        csum   = m_sum + int'(d);
        m_cnt  = 0;
      end else begin
        m_err      = 1;
        m_in_frame = 0;
        m_cnt      = 0;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (commit) begin
      if (m_q.size() < 2) m_q.push_back(csum);
      else m_ovf = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare all outputs mid-cycle, then apply the next inputs for the coming edge.
  task automatic step(input logic s, input logic e, input logic [7:0] d,
                      input logic r, input logic rs);
    logic [31:0] h;
    @(negedge clk);
    h = (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0;
    chk("dout", 32'(dout), 32'(h[9:0]));
    chk("dout_w9", 32'(dout9), 32'(h[8:0]));
    chk("dout_valid", 32'(dout_valid), 32'(m_q.size() > 0));
    chk("locked", 32'(locked), 32'(m_in_frame));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("ovf_w9", 32'(ovf9), 32'(m_ovf));
    sel        = s;
    en         = e;
    din        = d;
    dout_ready = r;
    rst        = rs;
    @(posedge clk);
    model_update(s, e, d, r, rs);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic [3:0] rdy);
    step(1'b1, 1'b0, a, rdy[0], 1'b0);
    step(1'b0, 1'b0, b, rdy[1], 1'b0);
    step(1'b0, 1'b0, c, rdy[2], 1'b0);
    step(1'b0, 1'b1, d, rdy[3], 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    model_update(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // Nominal frames straight out of reset.
    repeat (5) frame(8'd1, 8'd2, 8'd3, 8'd4, 4'hF);

    // Max sample values: 1020 at 10 bits, 508 wrapped at 9 bits.
    repeat (3) frame(8'd255, 8'd255, 8'd255, 8'd255, 4'hF);
    repeat (2) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

    // Backpressure: third sum dropped, overflow sticks, then drain.
    frame(8'd1, 8'd2, 8'd3, 8'd4, 4'h0);
    frame(8'd2, 8'd4, 8'd6, 8'd8, 4'h0);
    frame(8'd3, 8'd6, 8'd9, 8'd12, 4'h0);
    repeat (3) step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

    // Full FIFO with a pop in the commit cycle: push accepted, no overflow.
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    frame(8'd1, 8'd1, 8'd1, 8'd1, 4'h0);
    frame(8'd2, 8'd2, 8'd2, 8'd2, 4'h0);
    frame(8'd5, 8'd5, 8'd5, 8'd5, 4'b1000);
    repeat (4) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

    // sel at phase 2 restarts the frame with one error pulse.
    step(1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'd2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'd7, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'd8, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'd9, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'd10, 1'b1, 1'b0);

    // sel+en together at phase 0: plain frame start.
    step(1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'd1, 1'b1, 1'b0);

    // en at phase 1 drops lock; nothing emitted until the next sel.
    step(1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'd4, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 8'd5, 1'b1, 1'b0);
    frame(8'd10, 8'd20, 8'd30, 8'd40, 4'hF);

    // Reset at phase 2 with one sum queued, then a clean restart.
    frame(8'd1, 8'd2, 8'd3, 8'd4, 4'h0);
    step(1'b1, 1'b0, 8'd9, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd9, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd9, 1'b0, 1'b1);
    repeat (2) frame(8'd6, 8'd7, 8'd8, 8'd9, 4'hF);

    // Random traffic: mostly legal frames, some stray strobes and rare resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
      end else begin
        step(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
             1'($urandom_range(0, 19) == 0));
      end
    end
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_sum_unit.md
# acc_sum_unit

Accumulator datapath at the receiving end of the accumulator controller's `sel`/`en` frame protocol. The controller marks each 4-sample frame with `sel` on the first sample and `en` on the last. This block sums the four `din` samples of each frame and checks that the strobes arrive at legal positions. Completed sums are queued in a 2-entry output FIFO with a valid/ready handshake toward the downstream consumer.

## Interface
- `DATA_W`, default 8: width of `din`, unsigned.
- `ACC_W`, default 10: accumulator/result width. Must be ≥ `DATA_W`+2 for lossless sums; narrower values wrap modulo 2^`ACC_W`.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sel`  in  1  frame-start strobe from the controller.
- `en`  in  1  frame-end strobe from the controller.
- `din`  in  `DATA_W`  sample, valid every cycle.
- `dout`  out  `ACC_W`  FIFO head (frame sum).
- `dout_valid`  out  1  FIFO not empty.
- `dout_ready`  in  1  consumer accepts the head on a cycle where `dout_valid` && `dout_ready`.
- `locked`  out  1  high while in state RUN.
- `frame_err`  out  1  one-cycle pulse on a protocol violation.
- `ovf`  out  1  sticky; set when a completed sum is dropped because the FIFO is full.

## Operation
- **States:** HUNT, RUN. Phase counter `ph` runs 0..3 and is meaningful only in RUN.
- **HUNT:**
  - `en` and non-`sel` cycles are ignored, with no error.
  - On `sel`: `acc` ← `din`, go to RUN, `ph` ← 1.
- **RUN, `sel`=1:**
  - If `ph`≠0, pulse `frame_err` (the partial frame is discarded).
  - In all cases `acc` ← `din` and `ph` ← 1. `sel` always restarts a frame.
- **RUN, `ph`=1 or 2, `sel`=0:**
  - If `en`=1: pulse `frame_err`, go to HUNT, discard the frame.
  - Otherwise `acc` ← `acc`+`din` and `ph` ← `ph`+1.
- **RUN, `ph`=3, `sel`=0:**
  - If `en`=1: commit `acc`+`din` to the FIFO and set `ph` ← 0.
  - If `en`=0: pulse `frame_err` and go to HUNT.
- **RUN, `ph`=0, `sel`=0:** pulse `frame_err`, go to HUNT (missing frame start).
- **`sel` and `en` both high:** `sel` takes precedence. If `ph`≠0, `frame_err` pulses once (not twice).
- **Commit while FIFO is full:**
  - If a pop occurs in the same cycle, the push succeeds.
  - Otherwise the sum is dropped and `ovf` ← 1.
- **Arithmetic:** `din` is zero-extended to `ACC_W`; sums wrap modulo 2^`ACC_W`.
- **Reset values:** state HUNT, `ph` 0, `acc` 0, FIFO empty, `dout` 0, `dout_valid` 0, `locked` 0, `frame_err` 0, `ovf` 0.
- **`rst` mid-frame or with the FIFO occupied:** everything returns to the reset values. Queued sums are lost.

## Timing
- All strobes and `din` are sampled at the same edge.
- **Latency:** sum visible on `dout` with `dout_valid`=1 exactly 1 cycle after the `en` cycle. There is no bypass, even when the FIFO is empty and `dout_ready`=1.
- **FIFO behaviour:**
  - Show-ahead: `dout` is the head.
  - Pop takes effect at the edge where valid && ready.
  - `dout` and `dout_valid` must be stable while `dout_valid` && !`dout_ready`.
- **Sustained rate:** 1 sum per 4 cycles; the FIFO never fills if `dout_ready` is high at least 1 cycle in 4.
- **`frame_err` timing:** registered; high during the cycle after the offending sample.
- **`locked` timing:** registered from state; rises the cycle after the first accepted `sel`.
- The controller emits `sel` in the first cycle after its reset. With both blocks released together, the first sum appears 5 cycles after reset deasserts.

## Structure
- **Package `acc_pkg`:**
  - State enum (HUNT, RUN).
  - `FRAME_LEN`=4 and phase constants `PH_FIRST`=0, `PH_LAST`=3.
  - Shared with the controller so both ends agree on the frame length.
- **Sub-module `acc_out_fifo`:** 2-entry, `ACC_W` wide, with push/full/pop/empty/head ports.
- Top level contains the state machine, phase counter, accumulator and checker.

## Test plan
- **Controller-driven nominal:** connect the `sel`/`en` pattern, `din` = 1,2,3,4 repeating, `dout_ready`=1 → `dout`=10 every 4th cycle; first sum 5 cycles after reset; `frame_err`=0, `ovf`=0.
- **Max values:** `din`=255 for all four samples with `ACC_W`=10 → `dout`=1020. Repeat with `ACC_W`=9 → `dout`=508 (wrapped).
- **Backpressure:** `dout_ready`=0 for 3 frames with sums 10, 20, 30 → FIFO holds 10 and 20 (head 10 stable); 30 dropped; `ovf`=1 and stays 1. Release `dout_ready` → 10 then 20, then `dout_valid`=0.
- **Protocol errors:**
  - `sel` at `ph`=2 → one `frame_err` pulse, new frame restarts, next sum is correct.
  - `en` at `ph`=1 → `frame_err`, `locked` drops; no output until the next `sel`.
  - `sel`+`en` together at `ph`=0 → no error; frame starts.
- **Simultaneous push/pop with FIFO full:** `dout_ready` rises in the `en` cycle → the new sum is accepted and `ovf` stays 0.
- **Reset mid-frame:** `rst` at `ph`=2 with 1 entry queued → next cycle all outputs are at reset values; a clean restart yields correct sums.
